sixteen_to_four_priority_encoder: RTL
=====================================

Name: sixteen_to_four_priority_encoder

Overview:
- Sequential 16-to-4 priority encoder. It performs the inverse of the 4-to-16 binary decoder.
- It captures a 16-bit one-hot or multi-hot request vector and serially emits the 4-bit index {d,c,b,a} of each set bit, highest index first.
- Each index is emitted through a valid/ready handshake.
- Feeding every emitted code back through the 4-to-16 decoder and OR-ing the decoded results reproduces the captured vector.

Parameters:
- N_IN, 16, number of request lines. Fixed at 16 for this revision.
- CODE_W, 4, width of the emitted index. Must equal log2(N_IN).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- en  input  1  global enable, mirroring the decoder's enable.
- load  input  1  capture strobe for req.
- req  input  16  request vector; bit i requests index i.
- code  output  4  emitted index; code[3]=d, code[0]=a.
- code_valid  output  1  code is valid this cycle.
- code_ready  input  1  consumer accepts code.
- busy  output  1  high while captured bits remain to be emitted.
- done  output  1  one-cycle pulse after the last code is accepted.
- empty  output  1  one-cycle pulse when a loaded vector was all zero.

Behaviour:
- Registers: pending[15:0], state, done_r, empty_r.
- code and code_valid are decoded only from registered state. There is no combinational path from req, load or code_ready to code or code_valid.
- Reset (n_rst=0 at a clk edge):
  - state=IDLE, pending=0.
  - code=0, code_valid=0, busy=0, done=0, empty=0.
  - Reset wins over every other input, including mid-EMIT. Any partially emitted vector is discarded.
- en=0:
  - All registers hold.
  - code_valid is forced to 0; no transfer occurs and load is ignored.
  - done and empty are forced to 0. A pulse pending when en falls is deferred until en returns, then lasts exactly one cycle.
- State IDLE:
  - busy=0, code_valid=0, code=0.
  - If en & load: pending<=req.
  - If req!=0, go to EMIT. If req==0, set empty=1 for the next cycle and stay in IDLE.
- State EMIT:
  - busy=1, code_valid=en, code=index of the highest set bit of pending.
  - Transfer condition: en & code_valid & code_ready. On transfer, clear that bit in pending.
  - If the cleared pending is 0, go to DONE; otherwise stay in EMIT.
  - Throughput is one code per cycle when code_ready is held high.
  - If no transfer occurs, code and code_valid hold stable (AXI-style: valid does not drop without a transfer while en=1).
  - load is ignored in EMIT.
- State DONE:
  - done=1 for exactly one cycle, busy=0, code_valid=0.
  - Go to IDLE unconditionally. load in this cycle is ignored.
- Latency: a load accepted at edge N produces code_valid=1 with the first code in cycle N+1. The done pulse appears in the cycle after the final transfer.
- Boundary cases:
  - req=16'h0001 emits a single code 0.
  - req=16'hFFFF emits 15 down to 0 in 16 transfers.
  - code_ready held high while in IDLE has no effect.
  - Simultaneous load and code_ready in IDLE: load is processed; ready is don't-care.

Test Plan:
1. Reset: hold n_rst=0 for 2 cycles with random inputs.
   -> code=0, code_valid=0, busy=0, done=0, empty=0. pending is empty: after release, code_valid stays 0 with no load.
2. Load req=16'h8421 with code_ready=1.
   -> Codes 15, 10, 5, 0 on 4 consecutive cycles starting 1 cycle after load.
   -> busy high for those 4 cycles, then done=1 for 1 cycle, then IDLE.
3. Backpressure: load req=16'h0003, hold code_ready=0 for 3 cycles, then raise it to 1.
   -> code=1 with valid held for 3 cycles, then code 1 transfers, then code 0 transfers, then done.
4. Load req=16'h0000.
   -> empty=1 for exactly 1 cycle, code_valid never asserts, busy=0, done=0.
5. Enable gating: load req=16'hFFFF, drop en for 5 cycles after 3 transfers, then restore it.
   -> code_valid=0 while en=0. Resumes at code 12. Exactly 16 distinct codes total (15 to 0), then one done pulse.
6. Ignored load and reset mid-operation:
   - Assert load with req=16'h00F0 while EMIT is processing 16'h0300 -> emitted codes are only 9 and 8.
   - Reload 16'h0300 and assert n_rst=0 after 1 transfer -> next cycle idle with code_valid=0; a fresh load of 16'h0010 emits only code 4.
   - Scoreboard: decoding all emitted codes via the 4-to-16 decoder reproduces each accepted req.

Source files
------------

// File: rtl/sixteen_to_four_priority_encoder.sv
// Sequential 16-to-4 priority encoder: captures a request vector and serially
// emits the index of every set bit, highest first, over a valid/ready handshake.
module sixteen_to_four_priority_encoder #(
    parameter int N_IN   = 16,
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic              load,
    input  logic [N_IN-1:0]   req,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              busy,
    output logic              done,
    output logic              empty
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [N_IN-1:0]   pending;
    logic              done_r;
    logic              empty_r;
    logic [CODE_W-1:0] top_idx;
    logic [N_IN-1:0]   pending_next;

    // Later (higher) set bits override earlier ones, leaving the highest index.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (pending[i]) begin
                top_idx = CODE_W'(i);
            end
        end
    end

    assign pending_next = pending & ~(N_IN'(1) << top_idx);

    assign busy       = (state == EMIT);
    assign code_valid = en & (state == EMIT);
    assign code       = (state == EMIT) ? top_idx : '0;
    assign done       = en & done_r;
    assign empty      = en & empty_r;

    // With en low every register holds, so a pending done/empty pulse is
    // simply deferred until en returns.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            pending <= '0;
            done_r  <= 1'b0;
            empty_r <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    done_r  <= 1'b0;
                    empty_r <= 1'b0;
                    if (load) begin
                        pending <= req;
                        if (|req) begin
                            state <= EMIT;
                        end else begin
                            empty_r <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    empty_r <= 1'b0;
                    if (code_ready) begin
                        pending <= pending_next;
                        if (pending_next == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    empty_r <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                    done_r  <= 1'b0;
                    empty_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
